fft_index_counter: RTL and testbench

//  Parametrised nested counter that sequences FFT butterfly indices: inner index 0..N/2-1

---
 rtl/fft_cim_pkg.sv | 26 ++
 rtl/mod_counter.sv | 28 ++
 rtl/fft_index_counter.sv | 97 +++++++++
 tb/tb_fft_index_counter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cim_pkg.sv
// Shared definitions for the fft_cim address-generation blocks.
package fft_cim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Stage counter width: enough bits for 0..log2n-1, never narrower than one bit.
  function automatic int unsigned stg_width(input int unsigned log2n);
    int unsigned w;
    w = $clog2(log2n);
    return (w < 1) ? 1 : w;
  endfunction

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter 0..MAX with synchronous clear and advance enable.
// wrap flags the cycle in which an enabled count rolls MAX back to 0.
module mod_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] QMAX = W'(MAX);

  assign wrap = en & (q == QMAX);

  // Count register: reset/clear to zero, otherwise advance modulo MAX+1 when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == QMAX) ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/fft_index_counter.sv
// FFT butterfly index sequencer: inner index 0..N/2-1 nested inside stage 0..LOG2N-1,
// with start/abort control, stall enable, bit-reversed index and continuous-frame mode.
module fft_index_counter
  import fft_cim_pkg::*;
#(
  parameter  int unsigned LOG2N = 4,
  parameter  int unsigned FRM_W = 8,
  localparam int unsigned IDX_W = LOG2N - 1,
  localparam int unsigned STG_W = stg_width(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic             cont,
  output logic             busy,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_rev,
  output logic [STG_W-1:0] stage,
  output logic             last,
  output logic             done,
  output logic [FRM_W-1:0] frames
);

  localparam int unsigned IDX_MAX = (2 ** IDX_W) - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IDX_MAX);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2N - 1);

  state_t state;
  logic   step;
  logic   idx_wrap;
  logic   stg_wrap;

  // A step is only accepted while running; abort overrides it in the same cycle.
  assign step = (state == RUN) & en & ~abort;

  // The final step wraps both counters to zero on their own, so a continuous-mode
  // restart needs no explicit clear and leaves no bubble between frames.
  mod_counter #(
    .W   (IDX_W),
    .MAX (IDX_MAX)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .en   (step),
    .q    (idx),
    .wrap (idx_wrap)
  );

  mod_counter #(
    .W   (STG_W),
    .MAX (LOG2N - 1)
  ) u_stage (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .en   (idx_wrap),
    .q    (stage),
    .wrap (stg_wrap)
  );

  assign busy    = (state == RUN);
  assign last    = busy & (stage == STG_LAST) & (idx == IDX_LAST);
  assign idx_rev = IDX_W'(bit_rev(32'(idx), IDX_W));

  // Control FSM with registered done pulse and completed-frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      frames <= '0;
    end else if (abort) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (step && stg_wrap) begin
            done   <= 1'b1;
            frames <= frames + FRM_W'(1);
            state  <= cont ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_index_counter.sv
// Randomised self-checking bench for fft_index_counter at LOG2N=3 (12 steps per frame).
// A second instance with FRM_W=2 shares the stimulus to observe frame-count wrap.
module tb_fft_index_counter;

  localparam int unsigned LOG2N = 3;
  localparam int STEPS = 12;

  logic       clk = 1'b0;
  logic       rst, start, abort, en, cont;
  logic       busy, last, done;
  logic [1:0] idx, idx_rev, stage;
  logic [7:0] frames;
  logic       busy2, last2, done2;
  logic [1:0] idx2, idx_rev2, stage2;
  logic [1:0] frames2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: position within the frame, running flag, done pulse, frame tally.
  bit m_run;
  int m_pos;
  bit m_done;
  int m_frames;

  fft_index_counter #(.LOG2N(LOG2N), .FRM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .cont(cont),
    .busy(busy), .idx(idx), .idx_rev(idx_rev), .stage(stage), .last(last),
    .done(done), .frames(frames)
  );

  fft_index_counter #(.LOG2N(LOG2N), .FRM_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .cont(cont),
    .busy(busy2), .idx(idx2), .idx_rev(idx_rev2), .stage(stage2), .last(last2),
    .done(done2), .frames(frames2)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] act_vec();
    return {busy, idx, idx_rev, stage, last, done, frames};
  endfunction

  function automatic logic [16:0] exp_vec();
    int i, s, r;
    i = m_pos % 4;
    s = m_pos / 4;
    r = ((i & 1) << 1) | (i >> 1);
    return {m_run, 2'(i), 2'(r), 2'(s), (m_run && m_pos == STEPS - 1), m_done, 8'(m_frames)};
  endfunction

  task automatic drive(input bit r, input bit s, input bit a, input bit e, input bit c);
    rst = r; start = s; abort = a; en = e; cont = c;
  endtask

  // Advance one clock and update the reference model from the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_run = 0; m_pos = 0; m_done = 0; m_frames = 0;
    end else if (abort) begin
      m_run = 0; m_pos = 0; m_done = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (start) m_run = 1;
    end else begin
      m_done = 0;
      if (en) begin
        if (m_pos == STEPS - 1) begin
          m_done = 1;
          m_frames = m_frames + 1;
          m_pos = 0;
          m_run = cont;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, 0, 0, 0);
    step();
    n_cmp++;
    if (act_vec() !== 17'd0) begin
      n_fail++;
      $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, act_vec(), 17'd0);
    end
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
    end
  endtask

  task automatic test_single_frame();
    int dones = 0;
    drive(0, 1, 0, 1, 0);
    step();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_frame cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (done) dones++;
      step();
    end
    n_cmp++;
    if (dones !== 1 || frames !== 8'd1) begin
      n_fail++;
      $display("FAIL single_frame_count dones=%0d frames=%0d exp dones=1 frames=1", dones, frames);
    end
  endtask

  task automatic test_toggle_en();
    drive(0, 1, 0, 0, 0);
    step();
    start = 0;
    for (int i = 0; i < 30; i++) begin
      en = (i % 2 == 0);
      step();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL toggle_en cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_cont();
    drive(0, 1, 0, 1, 1);
    step();
    start = 0;
    for (int i = 0; i < 3 * STEPS; i++) begin
      step();
      n_cmp++;
      if (act_vec() !== exp_vec() || (busy !== 1'b1 && i < 3 * STEPS - 1)) begin
        n_fail++;
        $display("FAIL cont cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
    cont = 0;
    for (int i = 0; i < STEPS + 2; i++) step();
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL cont_end cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
    end
  endtask

  task automatic test_abort();
    drive(0, 1, 0, 1, 0);
    step();
    start = 0;
    for (int i = 0; i < 6; i++) step();
    n_cmp++;
    if (stage !== 2'd1 || idx !== 2'd2) begin
      n_fail++;
      $display("FAIL abort_setup got stage=%0d idx=%0d exp stage=1 idx=2", stage, idx);
    end
    abort = 1;
    step();
    abort = 0;
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL abort cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
    end
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < STEPS + 2; i++) begin
      step();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL abort_restart cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_abort_final();
    drive(0, 1, 0, 1, 0);
    step();
    start = 1;
    for (int i = 0; i < STEPS - 1; i++) begin
      step();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL start_in_run cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
    start = 0;
    en = 0;
    step();
    n_cmp++;
    if (last !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_final_setup got last=%b exp=1", last);
    end
    en = 1;
    abort = 1;
    step();
    abort = 0;
    step();
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL abort_final cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
    end
  endtask

  task automatic test_frame_wrap();
    int base;
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 1, 1);
    step();
    start = 0;
    base = m_frames;
    for (int i = 0; i < 4 * STEPS; i++) begin
      step();
      n_cmp++;
      if (frames2 !== 2'(m_frames) || act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL frame_wrap cyc=%0d got frames2=%0d vec=%h exp frames2=%0d vec=%h",
                 cyc, frames2, act_vec(), 2'(m_frames), exp_vec());
      end
    end
    n_cmp++;
    if (frames2 !== 2'd0 || m_frames - base !== 4) begin
      n_fail++;
      $display("FAIL frame_wrap_final got frames2=%0d exp 0", frames2);
    end
    cont = 0;
    for (int i = 0; i < STEPS + 1; i++) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1));
      step();
      n_cmp++;
      if (act_vec() !== exp_vec() || frames2 !== 2'(m_frames)) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h f2=%0d exp=%h f2=%0d",
                 cyc, act_vec(), frames2, exp_vec(), 2'(m_frames));
      end
    end
  endtask

  initial begin
    m_run = 0; m_pos = 0; m_done = 0; m_frames = 0;
    drive(1, 0, 0, 0, 0);
    test_reset();
    test_single_frame();
    test_toggle_en();
    test_cont();
    test_abort();
    test_abort_final();
    test_frame_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
